// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the integer register file and its load scoreboard.
package reg_file_sb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int unsigned REG_ZERO   = 0;

endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: loads mark their destination pending at issue,
// the matching writeback clears it. Produces the decode stall term.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned A = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [A-1:0]      issue_rd,
  input  logic              wr_en,
  input  logic [A-1:0]      wr_addr,
  input  logic [A-1:0]      rs1_addr,
  input  logic [A-1:0]      rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              stall,
  output logic [(2**A)-1:0] busy_vec
);

  localparam int unsigned R = 2 ** A;

  logic [R-1:0] busy_q;
  logic [R-1:0] busy_d;
  logic         stall1;
  logic         stall2;

  // Next busy vector: clear on writeback first, then let a same-register
  // issue override it so the newer load stays pending. x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy vector register, discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Stall when a used, non-zero source is pending and its value is not
  // arriving on the writeback port this same cycle.
  always_comb begin
    stall1 = rs1_used && (rs1_addr != A'(REG_ZERO)) && busy_q[rs1_addr]
             && !(wr_en && (wr_addr == rs1_addr));
    stall2 = rs2_used && (rs2_addr != A'(REG_ZERO)) && busy_q[rs2_addr]
             && !(wr_en && (wr_addr == rs2_addr));
    stall  = stall1 || stall2;
  end

  assign busy_vec = busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// RV32I integer register file: 2 combinational read ports with same-cycle
// writeback bypass, 1 write port, plus a load-use busy scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned N = XLEN,
  parameter int unsigned A = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [A-1:0]      rs1_addr,
  input  logic [A-1:0]      rs2_addr,
  output logic [N-1:0]      rs1_data,
  output logic [N-1:0]      rs2_data,
  input  logic              wr_en,
  input  logic [A-1:0]      wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic              issue_valid,
  input  logic [A-1:0]      issue_rd,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              stall,
  output logic [(2**A)-1:0] busy_vec
);

  localparam int unsigned R = 2 ** A;

  logic [N-1:0] regs_q [R];
  logic         wr_live;

  // Writes to x0 are dropped so its storage stays at the reset value.
  assign wr_live = wr_en && (wr_addr != A'(REG_ZERO));

  // Register storage, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < R; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read port 1: x0 forced to zero, otherwise bypass the in-flight write.
  // Bypass is suppressed during reset so the outputs read zero throughout.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (!rst && wr_en && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
    end
    if (rst || (rs1_addr == A'(REG_ZERO))) begin
      rs1_data = '0;
    end
  end

  // Read port 2: same selection as port 1, independently addressed.
  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (!rst && wr_en && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
    end
    if (rst || (rs2_addr == A'(REG_ZERO))) begin
      rs2_data = '0;
    end
  end

  reg_scoreboard #(
    .A (A)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .stall       (stall),
    .busy_vec    (busy_vec)
  );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rs1_used;
  logic        rs2_used;
  logic        stall;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mreg [32];
  logic [31:0] mbusy;

  reg_file_sb #(
    .N (32),
    .A (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .stall       (stall),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_stall();
    logic s;
    s = 1'b0;
    if (rst) return 1'b0;
    if (rs1_used && rs1_addr != 5'd0 && mbusy[rs1_addr] && !(wr_en && wr_addr == rs1_addr)) s = 1'b1;
    if (rs2_used && rs2_addr != 5'd0 && mbusy[rs2_addr] && !(wr_en && wr_addr == rs2_addr)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_busy();
    return rst ? 32'h0 : mbusy;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mbusy = 32'h0;
  endtask

  // Clock-edge effect of the current inputs on the model.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        mreg[wr_addr]  = wr_data;
        mbusy[wr_addr] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e1, e2, eb;
    logic        es;
    e1 = exp_rd(rs1_addr);
    e2 = exp_rd(rs2_addr);
    es = exp_stall();
    eb = exp_busy();
    checks++;
    assert (rs1_data === e1) else begin
      errors++;
      $error("FAIL %s rs1_data got %h exp %h", tag, rs1_data, e1);
    end
    checks++;
    assert (rs2_data === e2) else begin
      errors++;
      $error("FAIL %s rs2_data got %h exp %h", tag, rs2_data, e2);
    end
    checks++;
    assert (stall === es) else begin
      errors++;
      $error("FAIL %s stall got %b exp %b", tag, stall, es);
    end
    checks++;
    assert (busy_vec === eb) else begin
      errors++;
      $error("FAIL %s busy_vec got %h exp %h", tag, busy_vec, eb);
    end
  endtask

  task automatic lit(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs set: check, take the edge, update model.
  task automatic cycle(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk); #1;
    cycle("reset0");
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555; rs1_addr = 5'd5;
    cycle("reset_write_ignored");
    idle();
    rst = 1'b0;

    // x0 write and issue ignored
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0; rs1_used = 1'b1;
    cycle("x0_write");
    idle(); rs1_used = 1'b1;
    #1 lit("x0_read", rs1_data, 32'h0);
    lit("x0_busy", {31'h0, busy_vec[0]}, 32'h0);
    lit("x0_stall", {31'h0, stall}, 32'h0);
    cycle("x0_after");

    // Same-cycle bypass, then storage
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1 lit("bypass_rs1", rs1_data, 32'h1234_5678);
    lit("bypass_rs2", rs2_data, 32'h1234_5678);
    cycle("bypass");
    wr_en = 1'b0; wr_data = 32'h0;
    #1 lit("stored_rs1", rs1_data, 32'h1234_5678);
    cycle("stored");

    // Load-use
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle("lu_issue");
    idle(); rs2_addr = 5'd3; rs2_used = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1 lit("lu_stall", {31'h0, stall}, 32'h1);
      cycle("lu_wait");
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
    #1 lit("lu_wb_stall", {31'h0, stall}, 32'h0);
    lit("lu_wb_data", rs2_data, 32'hA5);
    lit("lu_wb_busy", {31'h0, busy_vec[3]}, 32'h1);
    cycle("lu_wb");
    wr_en = 1'b0;
    #1 lit("lu_busy_clr", {31'h0, busy_vec[3]}, 32'h0);
    cycle("lu_after");

    // Set/clear collision
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle("col_issue");
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999_0009;
    cycle("col_both");
    idle(); rs1_addr = 5'd9;
    #1 lit("col_busy", {31'h0, busy_vec[9]}, 32'h1);
    lit("col_data", rs1_data, 32'h9999_0009);
    cycle("col_after");

    // Unused source
    idle();
    issue_valid = 1'b1; issue_rd = 5'd4;
    cycle("unused_issue");
    idle(); rs1_addr = 5'd4; rs1_used = 1'b0;
    #1 lit("unused_nostall", {31'h0, stall}, 32'h0);
    cycle("unused0");
    rs1_used = 1'b1;
    #1 lit("used_stall", {31'h0, stall}, 32'h1);
    cycle("used1");

    // Async reset mid-cycle
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    cycle("ar_write");
    idle(); rs1_addr = 5'd5; rs1_used = 1'b1;
    #1 lit("ar_pre", rs1_data, 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1 lit("ar_data", rs1_data, 32'h0);
    lit("ar_busy", busy_vec, 32'h0);
    lit("ar_stall", {31'h0, stall}, 32'h0);
    check_all("ar_all");
    @(posedge clk);
    model_edge();
    #1 rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0BAD_F00D;
    cycle("ar_wb");
    wr_en = 1'b0;
    #1 lit("ar_wb_stored", rs1_data, 32'h0BAD_F00D);
    cycle("ar_wb_after");

    // Random traffic on a narrow address range for frequent collisions
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      wr_en       = $urandom_range(0, 1);
      wr_addr     = 5'($urandom_range(0, 9));
      wr_data     = $urandom;
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom_range(0, 9));
      rs1_addr    = 5'($urandom_range(0, 9));
      rs2_addr    = 5'($urandom_range(0, 9));
      rs1_used    = $urandom_range(0, 1);
      rs2_used    = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) rs1_addr = wr_addr;
      cycle("rand");
    end
    rst = 1'b0;
    idle();
    cycle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Integer register file for the RV32I core: 32 x N-bit registers, two combinational read ports and one write port.
- Written at writeback; read by decode.
- Adds a per-register busy scoreboard. Multi-cycle loads mark their destination busy at issue and clear it at writeback. Decode gets a stall when a source is pending.
- Same-cycle write-to-read bypass, so decode sees the value being written back that cycle.

Parameters:
- N, 32, data width (XLEN).
- A, 5, register address width (2^A registers).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_addr  in  A  read port 1 address
- rs2_addr  in  A  read port 2 address
- rs1_data  out  N  read port 1 data (combinational)
- rs2_data  out  N  read port 2 data (combinational)
- wr_en  in  1  writeback enable
- wr_addr  in  A  writeback destination
- wr_data  in  N  writeback data
- issue_valid  in  1  a multi-cycle load to issue_rd issues this cycle
- issue_rd  in  A  destination of the issuing load
- rs1_used  in  1  decode instruction reads rs1
- rs2_used  in  1  decode instruction reads rs2
- stall  out  1  a used source is busy; hold decode
- busy_vec  out  2^A  scoreboard bits, for debug and verification

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is asynchronous, active-high.
  - While rst=1, all registers are 0 and all busy bits are 0.
  - Consequently rs1_data=rs2_data=0, stall=0 and busy_vec=0 during reset.
  - Reset asserted mid-operation discards pending loads. The next writeback after reset writes normally.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked busy: issue_rd=0 is ignored.
- Write: when wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data on the rising clk edge.
- Read and bypass:
  - rsX_data = 0 if rsX_addr=0.
  - Otherwise wr_data if wr_en=1 and wr_addr=rsX_addr (same cycle).
  - Otherwise reg[rsX_addr].
  - Both ports are independent; both may address the same register.
- Scoreboard update, per register r != 0, at the clock edge:
  - set = issue_valid and issue_rd=r.
  - clr = wr_en and wr_addr=r.
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r]).
  - Set has priority over clear on the same register in the same cycle: the older value is written back while the newer load is now pending.
- Stall (combinational):
  - stall = (rs1_used and rs1_addr!=0 and busy[rs1_addr] and not bypass1) or (the same term for rs2).
  - bypass1 = wr_en and wr_addr=rs1_addr, i.e. the pending value arrives this cycle, so no stall.
  - A write clears its busy bit one edge later; the bypass covers the intervening cycle.
- Latency:
  - Read: 0 cycles.
  - Write visible through storage: next cycle.
  - Write visible through bypass: same cycle.
- Writes to a non-busy register behave normally (ALU results). The scoreboard only tracks issued loads.
- No counters wrap. Issuing to an already-busy register simply keeps it busy.

Decomposition:
- Shared package: XLEN=32, REG_ADDR_W=5, NUM_REGS=32, constant REG_ZERO=0.
- One natural sub-module: reg_scoreboard. It holds the busy vector, applies the set/clear priority, and produces the stall term. The storage array and bypass mux stay in reg_file_sb.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing x5=0xDEADBEEF -> rs1_data(x5)=0, busy_vec=0, stall=0 immediately, without waiting for clk.
- x0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; issue_valid=1, issue_rd=0 -> x0 reads 0, busy_vec[0]=0, stall=0 with rs1_addr=0, rs1_used=1.
- Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0x12345678, rs1_addr=rs2_addr=7 -> both read 0x12345678 before the edge and from storage after it.
- Load-use: issue_rd=3 at cycle 0; cycles 1-3 rs2_addr=3, rs2_used=1 -> stall=1; writeback x3=0xA5 at cycle 4 -> stall=0 and rs2_data=0xA5 that cycle, busy_vec[3]=0 from cycle 5.
- Set/clear collision: busy[9]=1; same cycle wr_en to x9 plus issue_valid with issue_rd=9 -> busy[9] remains 1 and x9 holds the written data.
- Unused source: busy[4]=1, rs1_addr=4, rs1_used=0 -> stall=0; then rs1_used=1 -> stall=1.
